rgb_sram_pixel_reader: RTL and testbench
========================================

Name: rgb_sram_pixel_reader

Overview:
Downstream of the YUV-to-RGB colour-space-conversion stage. Reads the packed RGB image that stage leaves in SRAM: 3 words per pixel pair, {R0,G0}, {B0,R1}, {G1,B1}. Unpacks the words and presents one 24-bit pixel per handshake, in raster order, to the VGA/display consumer. Prefetches through a small pair FIFO so SRAM read latency is hidden from the consumer.

Parameters:
RGB_START, 146944, SRAM word address of the first packed RGB word.
IMG_WIDTH, 320, pixels per row; must be even.
IMG_HEIGHT, 240, rows per frame.
FIFO_DEPTH, 4, pixel-pair FIFO entries; power of 2, minimum 2.

Ports:
Clock  in  1  system clock (50 MHz).
Resetn  in  1  asynchronous, active-low reset.
Start  in  1  single-cycle pulse; begins a frame read when idle or done.
Stop  out  1  level; high once the whole frame has been handed out; cleared by the next Start.
SRAM_address  out  18  read word address.
SRAM_write_data  out  16  constant 0 (block never writes).
SRAM_we_n  out  1  constant 1.
SRAM_read_data  in  16  read data, valid 2 cycles after its address is driven.
Pixel_ready  in  1  consumer accepts the current pixel.
Pixel_valid  out  1  R/G/B/flags hold a valid pixel.
Pixel_R, Pixel_G, Pixel_B  out  8 each  pixel colour.
Pixel_sof  out  1  current pixel is (0,0).
Pixel_eol  out  1  current pixel is column IMG_WIDTH-1.

Behaviour:
- Reset: Stop=0, Pixel_valid=0, Pixel_R/G/B=0, Pixel_sof=0, Pixel_eol=0, SRAM_address=RGB_START, SRAM_we_n=1, SRAM_write_data=0. FIFO empties; in-flight reads are discarded. Reset mid-frame returns the block to IDLE with no residual output.
- Total words per frame: N = IMG_WIDTH*IMG_HEIGHT*3/2 (115200 by default). Last address is RGB_START+N-1 = 262143. The 18-bit address must not wrap inside a frame.
- Fetch FSM states: IDLE, CHECK, RD0, RD1, RD2, DRAIN, DONE.
- IDLE/DONE: on Start, load word address to RGB_START and clear pixel counters, then go to CHECK. DONE also clears Stop on entry to CHECK. Start is ignored in all other states.
- CHECK: if fifo_count + pairs_in_flight < FIFO_DEPTH, go to RD0; otherwise stay.
- RD0, RD1, RD2: drive three consecutive addresses on three consecutive cycles, incrementing the address each cycle. After RD2, go to DRAIN if this was the last group, else to CHECK. CHECK adds 1 cycle, so the peak fetch rate is 1 pair per 4 cycles.
- Capture path: a 2-stage delayed valid plus word index (0/1/2) tracks each read. Word0 and word1 are latched. When word2 returns, push {R0,G0,B0,R1,G1,B1} into the FIFO in that same cycle. The FIFO can never overflow; overflow is an assertion failure.
- DRAIN: wait until pairs in flight = 0, FIFO empty and the last pixel has been accepted, then go to DONE and set Stop=1 in the same cycle.
- Output side: Pixel_valid = FIFO non-empty. A phase bit selects pixel 0 or 1 of the head pair. On Pixel_valid&&Pixel_ready the phase toggles; the pair is popped when phase was 1. R/G/B stay stable while valid&&!ready.
- Column counter wraps at IMG_WIDTH-1 and increments the row counter. Pixel_sof = (col==0 && row==0). Pixel_eol = (col==IMG_WIDTH-1).
- Simultaneous push and pop on one cycle: count unchanged; both take effect.
- Latency: from Start, the first Pixel_valid is at cycle 6 (CHECK, RD0..RD2, +2 read latency, push).

Optional Feature:
Macro RGB_READER_LOOP_EN.
- Defined: after the last group is issued, the FSM goes to CHECK with the address reloaded to RGB_START (continuous refresh). DRAIN/DONE are unused and Stop stays 0. Pixel_sof marks each new frame, and the column and row counters wrap back to 0 after the last pixel.
- Not defined: single-frame behaviour as above.

Test Plan:
- Reset mid-frame: assert Resetn=0 at pixel 500 -> Pixel_valid=0 within the same cycle. After release and Start, the first pixel is (0,0) with Pixel_sof=1.
- Unpack check, consumer always ready: SRAM words 0x1020,0x3040,0x5060 at 146944.. -> pixel0 R=0x10 G=0x20 B=0x30, pixel1 R=0x40 G=0x50 B=0x60.
- Full frame, ready=1: exactly 76800 accepted pixels. Pixel_eol on every 320th pixel. Last read address 262143. Stop=1 after the final accept; no read beyond 262143.
- Backpressure: hold ready=0 for 200 cycles -> no FIFO overflow, at most FIFO_DEPTH+pairs in flight fetched, pixel held stable. Release ready -> no pixels lost or duplicated (checked against a scoreboard).
- Random ready (50%): output stream matches a reference unpacking of the frame bit-exactly. Start pulses issued mid-frame are ignored.
- With RGB_READER_LOOP_EN: after 76800 pixels the next pixel has Pixel_sof=1 and equals pixel (0,0); Stop stays 0.

Source files
------------

// File: rtl/rgb_sram_pixel_reader.sv
// rgb_sram_pixel_reader
//
// Reads the packed RGB frame left in SRAM by the colour-space-conversion stage and
// streams it out one 24-bit pixel per valid/ready handshake, in raster order.
// Each pixel pair occupies three 16-bit words: {R0,G0}, {B0,R1}, {G1,B1}.
// Pairs are prefetched into a small FIFO so the 2-cycle SRAM read latency is hidden.
//
// Ports:
//   Clock, Resetn        system clock, asynchronous active-low reset
//   Start                one-cycle pulse, starts a frame when idle or done
//   Stop                 high once the whole frame has been handed out
//   SRAM_address         read word address
//   SRAM_write_data      tied to 0
//   SRAM_we_n            tied to 1 (read only)
//   SRAM_read_data       read data, valid 2 cycles after its address
//   Pixel_ready          consumer accepts the current pixel
//   Pixel_valid          a pixel is presented on Pixel_R/G/B/sof/eol
//   Pixel_R/G/B          pixel colour
//   Pixel_sof            current pixel is (0,0)
//   Pixel_eol            current pixel is the last column of its row
//
// Build option:
//   RGB_READER_LOOP_EN   when defined, the frame is re-read continuously; Stop stays low.

module rgb_sram_pixel_reader #(
  parameter int unsigned RGB_START  = 146944,
  parameter int unsigned IMG_WIDTH  = 320,
  parameter int unsigned IMG_HEIGHT = 240,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  output logic        Stop,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  input  logic        Pixel_ready,
  output logic        Pixel_valid,
  output logic [7:0]  Pixel_R,
  output logic [7:0]  Pixel_G,
  output logic [7:0]  Pixel_B,
  output logic        Pixel_sof,
  output logic        Pixel_eol
);

  localparam int unsigned NumPairs = IMG_WIDTH * IMG_HEIGHT / 2;
  localparam int unsigned PairW    = (NumPairs > 1) ? $clog2(NumPairs) : 1;
  localparam int unsigned ColW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned RowW     = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned PtrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW     = PtrW + 1;

  localparam logic [17:0]      StartAddr = 18'(RGB_START);
  localparam logic [PairW-1:0] LastPair  = PairW'(NumPairs - 1);
  localparam logic [ColW-1:0]  LastCol   = ColW'(IMG_WIDTH - 1);
  localparam logic [RowW-1:0]  LastRow   = RowW'(IMG_HEIGHT - 1);
  localparam logic [CntW-1:0]  Depth     = CntW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StRd0,
    StRd1,
    StRd2,
    StDrain,
    StDone
  } state_e;

  // Fetch side
  state_e             state_q, state_d;
  logic [17:0]        addr_q, addr_d;
  logic [PairW-1:0]   grp_q, grp_d;
  logic [CntW-1:0]    inflight_q, inflight_d;
  logic               stop_q, stop_d;
  logic               issue;
  logic [1:0]         issue_idx;
  logic               start_frame;
  logic               room;

  // Read-return tracking: two stages matching the SRAM latency
  logic               s1_v_q, s2_v_q;
  logic [1:0]         s1_idx_q, s2_idx_q;
  logic [15:0]        w0_q, w0_d, w1_q, w1_d;
  logic               push;

  // Pair FIFO
  logic [47:0]        fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               pop;

  // Output side
  logic               phase_q, phase_d;
  logic [ColW-1:0]    col_q, col_d;
  logic [RowW-1:0]    row_q, row_d;
  logic               accept;
  logic [47:0]        head;
  logic [23:0]        pix;

  assign room = ({1'b0, count_q} + {1'b0, inflight_q}) < {1'b0, Depth};

  // Fetch FSM: next state, address and group bookkeeping
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    grp_d       = grp_q;
    stop_d      = stop_q;
    issue       = 1'b0;
    issue_idx   = 2'd0;
    start_frame = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (Start) begin
          start_frame = 1'b1;
          addr_d      = StartAddr;
          grp_d       = '0;
          stop_d      = 1'b0;
          state_d     = StCheck;
        end
      end
      StCheck: begin
        if (room) begin
          state_d = StRd0;
        end
      end
      StRd0: begin
        issue     = 1'b1;
        issue_idx = 2'd0;
        addr_d    = addr_q + 18'd1;
        state_d   = StRd1;
      end
      StRd1: begin
        issue     = 1'b1;
        issue_idx = 2'd1;
        addr_d    = addr_q + 18'd1;
        state_d   = StRd2;
      end
      StRd2: begin
        issue     = 1'b1;
        issue_idx = 2'd2;
        if (grp_q == LastPair) begin
`ifdef RGB_READER_LOOP_EN
          addr_d  = StartAddr;
          grp_d   = '0;
          state_d = StCheck;
`else
          // Hold on the last word so the address never wraps past the top of SRAM.
          state_d = StDrain;
`endif
        end else begin
          addr_d  = addr_q + 18'd1;
          grp_d   = grp_q + PairW'(1);
          state_d = StCheck;
        end
      end
      StDrain: begin
        // An empty FIFO with nothing in flight means the final pair was popped,
        // i.e. the last pixel has been accepted.
        if ((inflight_q == '0) && (count_q == '0)) begin
          state_d = StDone;
          stop_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // A pair counts as in flight from its first read until its third word is pushed.
  always_comb begin
    inflight_d = inflight_q;
    if (issue && (issue_idx == 2'd0)) begin
      inflight_d = inflight_d + CntW'(1);
    end
    if (push) begin
      inflight_d = inflight_d - CntW'(1);
    end
  end

  // Capture words 0 and 1; word 2 is pushed straight from the bus with them.
  assign push = s2_v_q && (s2_idx_q == 2'd2);

  always_comb begin
    w0_d = w0_q;
    w1_d = w1_q;
    if (s2_v_q && (s2_idx_q == 2'd0)) begin
      w0_d = SRAM_read_data;
    end
    if (s2_v_q && (s2_idx_q == 2'd1)) begin
      w1_d = SRAM_read_data;
    end
  end

  // FIFO pointers and occupancy
  assign accept = Pixel_valid && Pixel_ready;
  assign pop    = accept && phase_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Pixel phase and raster position of the presented pixel
  always_comb begin
    phase_d = phase_q;
    col_d   = col_q;
    row_d   = row_q;
    if (start_frame) begin
      phase_d = 1'b0;
      col_d   = '0;
      row_d   = '0;
    end else if (accept) begin
      phase_d = ~phase_q;
      if (col_q == LastCol) begin
        col_d = '0;
        row_d = (row_q == LastRow) ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= StIdle;
      addr_q     <= StartAddr;
      grp_q      <= '0;
      inflight_q <= '0;
      stop_q     <= 1'b0;
      s1_v_q     <= 1'b0;
      s1_idx_q   <= 2'd0;
      s2_v_q     <= 1'b0;
      s2_idx_q   <= 2'd0;
      w0_q       <= '0;
      w1_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      phase_q    <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      grp_q      <= grp_d;
      inflight_q <= inflight_d;
      stop_q     <= stop_d;
      s1_v_q     <= issue;
      s1_idx_q   <= issue_idx;
      s2_v_q     <= s1_v_q;
      s2_idx_q   <= s1_idx_q;
      w0_q       <= w0_d;
      w1_q       <= w1_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      phase_q    <= phase_d;
      col_q      <= col_d;
      row_q      <= row_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge Clock) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {w0_q, w1_q, SRAM_read_data};
    end
  end

  fifo_no_overflow_a : assert property (@(posedge Clock) disable iff (!Resetn)
      !(push && !pop && (count_q == Depth)));

  // Outputs
  assign head = fifo_q[rd_ptr_q];
  assign pix  = phase_q ? head[23:0] : head[47:24];

  assign Pixel_valid     = (count_q != '0);
  assign Pixel_R         = Pixel_valid ? pix[23:16] : 8'h00;
  assign Pixel_G         = Pixel_valid ? pix[15:8]  : 8'h00;
  assign Pixel_B         = Pixel_valid ? pix[7:0]   : 8'h00;
  assign Pixel_sof       = Pixel_valid && (col_q == '0) && (row_q == '0);
  assign Pixel_eol       = Pixel_valid && (col_q == LastCol);
  assign Stop            = stop_q;
  assign SRAM_address    = addr_q;
  assign SRAM_write_data = 16'h0000;
  assign SRAM_we_n       = 1'b1;

endmodule

// File: tb/tb_rgb_sram_pixel_reader.sv
// Testbench for rgb_sram_pixel_reader. A small frame is placed at the very top of the
// 18-bit SRAM so the last word is 262143; the pixel stream is checked against a
// reference unpacking of the memory contents.
`timescale 1ns/1ps

module tb_rgb_sram_pixel_reader;

  localparam int unsigned W      = 16;
  localparam int unsigned H      = 8;
  localparam int unsigned Depth  = 4;
  localparam int unsigned Words  = W * H * 3 / 2;
  localparam int unsigned Pix    = W * H;
  localparam int unsigned StartA = 262144 - Words;
  localparam logic [17:0] StartAddr = 18'(StartA);
  localparam logic [17:0] LastAddr  = 18'h3FFFF;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        Start = 1'b0;
  logic        Stop;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;
  logic        Pixel_ready = 1'b0;
  logic        Pixel_valid;
  logic [7:0]  Pixel_R, Pixel_G, Pixel_B;
  logic        Pixel_sof, Pixel_eol;
  logic [25:0] cur;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [Words];
  logic [17:0] a1, a2;

  logic [25:0] got_q [$];
  int          unstable;
  logic [17:0] amin, amax, amax_hold;

  rgb_sram_pixel_reader #(
    .RGB_START (StartA),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .FIFO_DEPTH(Depth)
  ) dut (
    .Clock          (Clock),
    .Resetn         (Resetn),
    .Start          (Start),
    .Stop           (Stop),
    .SRAM_address   (SRAM_address),
    .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n      (SRAM_we_n),
    .SRAM_read_data (SRAM_read_data),
    .Pixel_ready    (Pixel_ready),
    .Pixel_valid    (Pixel_valid),
    .Pixel_R        (Pixel_R),
    .Pixel_G        (Pixel_G),
    .Pixel_B        (Pixel_B),
    .Pixel_sof      (Pixel_sof),
    .Pixel_eol      (Pixel_eol)
  );

  always #10 Clock = ~Clock;

  // SRAM model: data for an address appears two cycles after it is driven.
  always @(posedge Clock) begin
    a1 <= SRAM_address;
    a2 <= a1;
  end
  assign SRAM_read_data = (a2 >= StartAddr) ? mem[int'(a2 - StartAddr)] : 16'hDEAD;

  assign cur = {Pixel_R, Pixel_G, Pixel_B, Pixel_sof, Pixel_eol};

  // Reference: pixel k of the (repeating) frame unpacked from memory.
  function automatic logic [25:0] ref_pix(input int unsigned k);
    int unsigned kk, p, col;
    logic [15:0] w0, w1, w2;
    logic [7:0]  r, g, b;
    kk = k % Pix;
    p  = kk / 2;
    w0 = mem[3 * p];
    w1 = mem[3 * p + 1];
    w2 = mem[3 * p + 2];
    if ((kk % 2) == 0) begin
      r = w0[15:8]; g = w0[7:0];  b = w1[15:8];
    end else begin
      r = w1[7:0];  g = w2[15:8]; b = w2[7:0];
    end
    col = kk % W;
    return {r, g, b, (kk == 0), (col == W - 1)};
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < int'(Words); i++) mem[i] = 16'($urandom);
  endtask

  task automatic apply_reset();
    Resetn = 1'b0;
    Start = 1'b0;
    Pixel_ready = 1'b0;
    repeat (3) @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  // Drives the consumer and records accepted pixels, hold stability and addresses.
  task automatic collect(input int n, input int pct, input int hold, input bit rand_start,
                         input int max_cycles);
    int cyc;
    bit rdy, prev_hold;
    logic [25:0] prev_pix;
    got_q.delete();
    unstable = 0;
    amin = '1;
    amax = '0;
    amax_hold = '0;
    cyc = 0;
    prev_hold = 1'b0;
    prev_pix = '0;
    while (got_q.size() < n && cyc < max_cycles) begin
      @(negedge Clock);
      cyc++;
      if (SRAM_address < amin) amin = SRAM_address;
      if (SRAM_address > amax) amax = SRAM_address;
      if (cyc == hold) amax_hold = amax;
      if (prev_hold && (!Pixel_valid || cur !== prev_pix)) unstable++;
      rdy = (cyc <= hold) ? 1'b0 : ($urandom_range(99) < pct);
      Pixel_ready = rdy;
      Start = rand_start && ($urandom_range(15) == 0);
      if (Pixel_valid && rdy) got_q.push_back(cur);
      prev_hold = Pixel_valid && !rdy;
      prev_pix = cur;
    end
    @(posedge Clock);
    #1;
    Pixel_ready = 1'b0;
    Start = 1'b0;
    @(negedge Clock);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (Stop !== 1'b0) begin errors++; $display("FAIL reset_stop: got %b want 0", Stop); end
    checks++; if (Pixel_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", Pixel_valid); end
    checks++; if ({Pixel_R, Pixel_G, Pixel_B} !== 24'h0) begin errors++; $display("FAIL reset_rgb: got %h want 0", {Pixel_R, Pixel_G, Pixel_B}); end
    checks++; if ({Pixel_sof, Pixel_eol} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {Pixel_sof, Pixel_eol}); end
    checks++; if (SRAM_address !== StartAddr) begin errors++; $display("FAIL reset_addr: got %h want %h", SRAM_address, StartAddr); end
    checks++; if (SRAM_we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n: got %b want 1", SRAM_we_n); end
    checks++; if (SRAM_write_data !== 16'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", SRAM_write_data); end
  endtask

  task automatic test_unpack();
    int lat;
    fill_mem();
    mem[0] = 16'h1020;
    mem[1] = 16'h3040;
    mem[2] = 16'h5060;
    apply_reset();
    pulse_start();
    lat = 0;
    while (!Pixel_valid && lat < 50) begin
      @(negedge Clock);
      lat++;
    end
    checks++; if (lat != 6) begin errors++; $display("FAIL first_latency: got %0d want 6", lat); end
    collect(2, 100, 0, 1'b0, 100);
    checks++;
    if (got_q.size() != 2) begin
      errors++; $display("FAIL unpack_count: got %0d want 2", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== {8'h10, 8'h20, 8'h30, 1'b1, 1'b0}) begin
        errors++; $display("FAIL unpack_pix0: got %h want %h", got_q[0], {8'h10, 8'h20, 8'h30, 2'b10});
      end
      checks++;
      if (got_q[1] !== {8'h40, 8'h50, 8'h60, 1'b0, 1'b0}) begin
        errors++; $display("FAIL unpack_pix1: got %h want %h", got_q[1], {8'h40, 8'h50, 8'h60, 2'b00});
      end
    end
  endtask

  task automatic test_full_frame();
    int eols, wait_cyc;
    fill_mem();
    apply_reset();
    pulse_start();
    collect(Pix, 100, 0, 1'b0, Pix * 4 + 300);
    checks++; if (got_q.size() != Pix) begin errors++; $display("FAIL frame_count: got %0d want %0d", got_q.size(), Pix); end
    eols = 0;
    foreach (got_q[i]) begin
      checks++;
      if (got_q[i] !== ref_pix(i)) begin errors++; $display("FAIL frame_pix[%0d]: got %h want %h", i, got_q[i], ref_pix(i)); end
      if (got_q[i][0]) eols++;
    end
    checks++; if (eols != H) begin errors++; $display("FAIL frame_eols: got %0d want %0d", eols, H); end
    checks++; if (amax !== LastAddr) begin errors++; $display("FAIL frame_last_addr: got %h want %h", amax, LastAddr); end
    checks++; if (amin !== StartAddr) begin errors++; $display("FAIL frame_min_addr: got %h want %h", amin, StartAddr); end
`ifndef RGB_READER_LOOP_EN
    checks++; if (Stop !== 1'b0) begin errors++; $display("FAIL frame_stop_early: got %b want 0", Stop); end
    wait_cyc = 0;
    while (Stop !== 1'b1 && wait_cyc < 10) begin
      @(negedge Clock);
      wait_cyc++;
    end
    checks++; if (Stop !== 1'b1) begin errors++; $display("FAIL frame_stop: got %b want 1", Stop); end
    repeat (20) @(negedge Clock);
    checks++; if (Pixel_valid !== 1'b0) begin errors++; $display("FAIL frame_extra_pixel: got %b want 0", Pixel_valid); end
    checks++; if (SRAM_address !== LastAddr) begin errors++; $display("FAIL frame_park_addr: got %h want %h", SRAM_address, LastAddr); end
`else
    repeat (20) @(negedge Clock);
    checks++; if (Stop !== 1'b0) begin errors++; $display("FAIL loop_stop: got %b want 0", Stop); end
`endif
  endtask

  task automatic test_backpressure();
    fill_mem();
    apply_reset();
    pulse_start();
    collect(Pix, 100, 200, 1'b0, 200 + Pix * 4 + 300);
    checks++; if (unstable != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles want 0", unstable); end
    checks++;
    if (amax_hold > StartAddr + 18'(3 * Depth)) begin
      errors++; $display("FAIL bp_overfetch: got %h want <= %h", amax_hold, StartAddr + 18'(3 * Depth));
    end
    checks++;
    if (amax_hold < StartAddr + 18'(3 * Depth - 1)) begin
      errors++; $display("FAIL bp_fill: got %h want >= %h", amax_hold, StartAddr + 18'(3 * Depth - 1));
    end
    checks++; if (got_q.size() != Pix) begin errors++; $display("FAIL bp_count: got %0d want %0d", got_q.size(), Pix); end
    foreach (got_q[i]) begin
      checks++;
      if (got_q[i] !== ref_pix(i)) begin errors++; $display("FAIL bp_pix[%0d]: got %h want %h", i, got_q[i], ref_pix(i)); end
    end
  endtask

  task automatic test_random_ready();
    int wait_cyc;
    fill_mem();
    apply_reset();
    pulse_start();
    collect(Pix, 50, 0, 1'b1, Pix * 10 + 300);
    checks++; if (got_q.size() != Pix) begin errors++; $display("FAIL rnd_count: got %0d want %0d", got_q.size(), Pix); end
    checks++; if (unstable != 0) begin errors++; $display("FAIL rnd_stable: got %0d unstable cycles want 0", unstable); end
    foreach (got_q[i]) begin
      checks++;
      if (got_q[i] !== ref_pix(i)) begin errors++; $display("FAIL rnd_pix[%0d]: got %h want %h", i, got_q[i], ref_pix(i)); end
    end
`ifndef RGB_READER_LOOP_EN
    wait_cyc = 0;
    while (Stop !== 1'b1 && wait_cyc < 10) begin
      @(negedge Clock);
      wait_cyc++;
    end
    checks++; if (Stop !== 1'b1) begin errors++; $display("FAIL rnd_stop: got %b want 1", Stop); end
`else
    wait_cyc = 0;
`endif
  endtask

  task automatic test_reset_mid_frame();
    fill_mem();
    apply_reset();
    pulse_start();
    collect(50, 100, 0, 1'b0, 500);
    Resetn = 1'b0;
    #1;
    checks++; if (Pixel_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", Pixel_valid); end
    checks++; if ({Pixel_R, Pixel_G, Pixel_B} !== 24'h0) begin errors++; $display("FAIL midrst_rgb: got %h want 0", {Pixel_R, Pixel_G, Pixel_B}); end
    checks++; if (SRAM_address !== StartAddr) begin errors++; $display("FAIL midrst_addr: got %h want %h", SRAM_address, StartAddr); end
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
    checks++; if (Pixel_valid !== 1'b0) begin errors++; $display("FAIL midrst_residual: got %b want 0", Pixel_valid); end
    pulse_start();
    collect(Pix, 80, 0, 1'b0, Pix * 6 + 300);
    checks++; if (got_q.size() != Pix) begin errors++; $display("FAIL midrst_count: got %0d want %0d", got_q.size(), Pix); end
    foreach (got_q[i]) begin
      checks++;
      if (got_q[i] !== ref_pix(i)) begin errors++; $display("FAIL midrst_pix[%0d]: got %h want %h", i, got_q[i], ref_pix(i)); end
    end
  endtask

`ifdef RGB_READER_LOOP_EN
  task automatic test_loop();
    fill_mem();
    apply_reset();
    pulse_start();
    collect(Pix + 4, 70, 0, 1'b0, Pix * 8 + 300);
    checks++; if (got_q.size() != Pix + 4) begin errors++; $display("FAIL loop_count: got %0d want %0d", got_q.size(), Pix + 4); end
    foreach (got_q[i]) begin
      checks++;
      if (got_q[i] !== ref_pix(i)) begin errors++; $display("FAIL loop_pix[%0d]: got %h want %h", i, got_q[i], ref_pix(i)); end
    end
    if (got_q.size() > Pix) begin
      checks++; if (got_q[Pix][1] !== 1'b1) begin errors++; $display("FAIL loop_sof: got %b want 1", got_q[Pix][1]); end
    end
    checks++; if (Stop !== 1'b0) begin errors++; $display("FAIL loop_stop: got %b want 0", Stop); end
  endtask
`endif

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_unpack();
    test_full_frame();
    test_backpressure();
    test_random_ready();
    test_reset_mid_frame();
`ifdef RGB_READER_LOOP_EN
    test_loop();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
